mmcm_ps_responder: RTL and testbench

MMCM_PS_RESPONDER -- requirements
Module: mmcm_ps_responder

---
 rtl/mmcm_ps_pkg.sv | 26 ++
 rtl/ps_sat_counter.sv | 33 +++
 rtl/mmcm_ps_responder.sv | 146 ++++++++++++++
 tb/tb_mmcm_ps_responder.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmcm_ps_pkg.sv
// Shared types and constants for the MMCM phase-shift responder.
// mod_step handles both directions of the phase_mod wrap for any STEPS_PER_CYCLE.
package mmcm_ps_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } ps_state_e;

  localparam int DEF_PS_LATENCY      = 12;
  localparam int DEF_STEPS_PER_CYCLE = 224;
  localparam int SAT_W               = 16;
  localparam int MOD_W               = 16;
  localparam int LAT_CNT_W           = 8;

  function automatic logic [MOD_W-1:0] mod_step(input logic [MOD_W-1:0] cur,
                                                input logic             up,
                                                input logic [MOD_W-1:0] last);
    if (up) begin
      return (cur == last) ? '0 : cur + MOD_W'(1);
    end
    return (cur == '0) ? last : cur - MOD_W'(1);
  endfunction

endpackage

// File: rtl/ps_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module ps_sat_counter
  import mmcm_ps_pkg::*;
#(
  parameter int W = SAT_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_en_i && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mmcm_ps_responder.sv
// Behavioural stand-in for an MMCM dynamic phase-shift port: psen -> psdone
// after PS_LATENCY cycles, tracking net phase position and protocol errors.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | waiting for psen; accepts only while locked
//   ST_SHIFT | latency countdown; further psen flagged as overlap
//   ST_DONE  | psdone cycle; phase/counters already reflect the step
module mmcm_ps_responder
  import mmcm_ps_pkg::*;
#(
  parameter int PS_LATENCY      = DEF_PS_LATENCY,
  parameter int STEPS_PER_CYCLE = DEF_STEPS_PER_CYCLE,
  parameter int BIT_DEPTH       = 32
) (
  input  logic                        psclk,
  input  logic                        reset_n,
  input  logic                        locked,
  input  logic                        psen,
  input  logic                        psincdec,
  input  logic                        err_clr,
  output logic                        psdone,
  output logic                        busy,
  output logic signed [BIT_DEPTH-1:0] phase_pos,
  output logic [MOD_W-1:0]            phase_mod,
  output logic [SAT_W-1:0]            inc_count,
  output logic [SAT_W-1:0]            dec_count,
  output logic                        overlap_err,
  output logic                        unlocked_err
);

  // Two cycles of the latency are spent in the accept edge and the DONE entry.
  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(PS_LATENCY - 2);
  localparam logic [MOD_W-1:0]     MOD_LAST = MOD_W'(STEPS_PER_CYCLE - 1);

  ps_state_e                    state_q, state_d;
  logic [LAT_CNT_W-1:0]         cnt_q, cnt_d;
  logic                         dir_q, dir_d;
  logic                         psdone_q, psdone_d;
  logic                         busy_q, busy_d;
  logic signed [BIT_DEPTH-1:0]  phase_pos_q, phase_pos_d;
  logic [MOD_W-1:0]             phase_mod_q, phase_mod_d;
  logic                         ovl_q, ovl_d;
  logic                         unl_q, unl_d;
  logic                         complete;
  logic                         ovl_set;
  logic                         unl_set;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    complete = 1'b0;
    ovl_set  = 1'b0;
    unl_set  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (psen) begin
          if (locked) begin
            dir_d   = psincdec;
            cnt_d   = LAT_LOAD;
            state_d = ST_SHIFT;
          end else begin
            unl_set = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        ovl_set = psen;
        if (cnt_q == '0) begin
          state_d  = ST_DONE;
          complete = 1'b1;
        end else begin
          cnt_d = cnt_q - LAT_CNT_W'(1);
        end
      end
      ST_DONE: begin
        ovl_set = psen;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Phase state moves on the edge entering DONE so it is valid alongside psdone.
  always_comb begin
    psdone_d    = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
    phase_pos_d = phase_pos_q;
    phase_mod_d = phase_mod_q;
    if (complete) begin
      phase_pos_d = dir_q ? (phase_pos_q + BIT_DEPTH'(1)) : (phase_pos_q - BIT_DEPTH'(1));
      phase_mod_d = mod_step(phase_mod_q, dir_q, MOD_LAST);
    end
    ovl_d = ovl_set | (ovl_q & ~err_clr);
    unl_d = unl_set | (unl_q & ~err_clr);
  end

  always_ff @(posedge psclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      psdone_q    <= 1'b0;
      busy_q      <= 1'b0;
      phase_pos_q <= '0;
      phase_mod_q <= '0;
      ovl_q       <= 1'b0;
      unl_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      psdone_q    <= psdone_d;
      busy_q      <= busy_d;
      phase_pos_q <= phase_pos_d;
      phase_mod_q <= phase_mod_d;
      ovl_q       <= ovl_d;
      unl_q       <= unl_d;
    end
  end

  ps_sat_counter #(.W(SAT_W)) u_inc_cnt (
    .clk_i    (psclk),
    .rst_ni   (reset_n),
    .inc_en_i (complete & dir_q),
    .count_o  (inc_count)
  );

  ps_sat_counter #(.W(SAT_W)) u_dec_cnt (
    .clk_i    (psclk),
    .rst_ni   (reset_n),
    .inc_en_i (complete & ~dir_q),
    .count_o  (dec_count)
  );

  assign psdone       = psdone_q;
  assign busy         = busy_q;
  assign phase_pos    = phase_pos_q;
  assign phase_mod    = phase_mod_q;
  assign overlap_err  = ovl_q;
  assign unlocked_err = unl_q;

endmodule

// File: tb/tb_mmcm_ps_responder.sv
// Self-checking bench for mmcm_ps_responder: directed scenarios plus a random
// run compared against a timing-based reference model.
module tb_mmcm_ps_responder;

  localparam int LAT   = 12;
  localparam int STEPS = 224;

  logic               psclk = 1'b0;
  logic               reset_n = 1'b0;
  logic               locked = 1'b1;
  logic               psen = 1'b0;
  logic               psincdec = 1'b0;
  logic               err_clr = 1'b0;
  logic               psdone;
  logic               busy;
  logic signed [31:0] phase_pos;
  logic [15:0]        phase_mod;
  logic [15:0]        inc_count;
  logic [15:0]        dec_count;
  logic               overlap_err;
  logic               unlocked_err;

  int errors = 0;
  int checks = 0;

  // Reference model: an accepted request at cycle s occupies cycles s+1..s+LAT
  // and completes at s+LAT.
  int cyc = 0;
  bit m_active = 0;
  int m_start = 0;
  bit m_dir = 0;
  bit m_busy = 0, m_psdone = 0, m_ovl = 0, m_unl = 0;
  int m_phase = 0, m_mod = 0, m_inc = 0, m_dec = 0;

  mmcm_ps_responder #(
    .PS_LATENCY(LAT), .STEPS_PER_CYCLE(STEPS), .BIT_DEPTH(32)
  ) dut (
    .psclk(psclk), .reset_n(reset_n), .locked(locked), .psen(psen),
    .psincdec(psincdec), .err_clr(err_clr), .psdone(psdone), .busy(busy),
    .phase_pos(phase_pos), .phase_mod(phase_mod), .inc_count(inc_count),
    .dec_count(dec_count), .overlap_err(overlap_err), .unlocked_err(unlocked_err)
  );

  always #5 psclk = ~psclk;

  task automatic model_clear();
    m_active = 0; m_busy = 0; m_psdone = 0; m_ovl = 0; m_unl = 0;
    m_phase = 0; m_mod = 0; m_inc = 0; m_dec = 0;
  endtask

  task automatic tick();
    bit b_now, ovs, uns, clr;
    b_now = m_active && (cyc >= m_start + 1) && (cyc <= m_start + LAT);
    ovs = 0; uns = 0; clr = err_clr;
    if (psen) begin
      if (b_now) ovs = 1;
      else if (locked) begin m_active = 1; m_start = cyc; m_dir = psincdec; end
      else uns = 1;
    end
    @(posedge psclk); #1;
    cyc++;
    m_busy   = m_active && (cyc >= m_start + 1) && (cyc <= m_start + LAT);
    m_psdone = m_active && (cyc == m_start + LAT);
    if (m_psdone) begin
      if (m_dir) begin
        m_phase = m_phase + 1; m_mod = (m_mod + 1) % STEPS;
        if (m_inc < 65535) m_inc++;
      end else begin
        m_phase = m_phase - 1; m_mod = (m_mod + STEPS - 1) % STEPS;
        if (m_dec < 65535) m_dec++;
      end
    end
    m_ovl = ovs | (m_ovl & !clr);
    m_unl = uns | (m_unl & !clr);
  endtask

  task automatic do_reset();
    psen = 0; err_clr = 0; psincdec = 0; locked = 1;
    reset_n = 0;
    repeat (2) @(posedge psclk);
    #1; cyc += 2;
    model_clear();
    reset_n = 1;
  endtask

  task automatic wait_done(input int budget, output bit seen, output int waited);
    seen = 0; waited = 0;
    while (!seen && waited < budget) begin
      tick(); waited++;
      if (psdone) seen = 1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({psdone, busy, overlap_err, unlocked_err} !== 4'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {psdone, busy, overlap_err, unlocked_err});
    end
    checks++;
    if (phase_pos !== 0 || phase_mod !== 0 || inc_count !== 0 || dec_count !== 0) begin
      errors++; $display("FAIL reset_values: got pos=%0d mod=%0d inc=%0d dec=%0d want all 0",
                         phase_pos, phase_mod, inc_count, dec_count);
    end
  endtask

  task automatic test_single_inc();
    psen = 1; psincdec = 1; tick(); psen = 0; psincdec = 0;
    for (int k = 1; k <= LAT + 1; k++) begin
      if (k > 1) tick();
      checks++;
      if (busy !== (k <= LAT) || psdone !== (k == LAT)) begin
        errors++; $display("FAIL single_timing cycle %0d: got busy=%b psdone=%b want busy=%b psdone=%b",
                           k, busy, psdone, k <= LAT, k == LAT);
      end
    end
    checks++;
    if (phase_pos !== 1 || phase_mod !== 1 || inc_count !== 1 || dec_count !== 0) begin
      errors++; $display("FAIL single_result: got pos=%0d mod=%0d inc=%0d dec=%0d want 1 1 1 0",
                         phase_pos, phase_mod, inc_count, dec_count);
    end
  endtask

  task automatic test_back_to_back_wrap();
    bit seen; int waited; int bad_lat = 0; int timeouts = 0;
    do_reset();
    for (int i = 0; i < STEPS; i++) begin
      psen = 1; psincdec = 1; tick(); psen = 0;
      wait_done(LAT + 8, seen, waited);
      if (!seen) timeouts++;
      else if (waited != LAT - 1) bad_lat++;
      tick();
    end
    checks++;
    if (timeouts != 0 || bad_lat != 0) begin
      errors++; $display("FAIL wrap_latency: got timeouts=%0d bad_latency=%0d want 0 0", timeouts, bad_lat);
    end
    checks++;
    if (phase_mod !== 0 || phase_pos !== STEPS) begin
      errors++; $display("FAIL wrap_phase: got mod=%0d pos=%0d want 0 %0d", phase_mod, phase_pos, STEPS);
    end
    checks++;
    if (overlap_err !== 0 || inc_count !== STEPS) begin
      errors++; $display("FAIL wrap_status: got ovl=%b inc=%0d want 0 %0d", overlap_err, inc_count, STEPS);
    end
  endtask

  task automatic test_dec_from_zero();
    bit seen; int waited;
    do_reset();
    psen = 1; psincdec = 0; tick(); psen = 0; psincdec = 1;
    wait_done(LAT + 8, seen, waited);
    checks++;
    if (!seen) begin errors++; $display("FAIL dec_timeout: got no psdone want psdone"); end
    checks++;
    if (phase_mod !== STEPS - 1 || phase_pos !== -1 || dec_count !== 1 || inc_count !== 0) begin
      errors++; $display("FAIL dec_result: got mod=%0d pos=%0d dec=%0d inc=%0d want %0d -1 1 0",
                         phase_mod, phase_pos, dec_count, inc_count, STEPS - 1);
    end
    tick();
  endtask

  task automatic test_overlap();
    int n_done = 0; int done_at = -1; int s;
    do_reset();
    s = cyc;
    psen = 1; psincdec = 1; tick(); psen = 0;
    repeat (4) tick();
    psen = 1; psincdec = 0; tick(); psen = 0;
    while (cyc < s + 20) begin
      tick();
      if (psdone) begin n_done++; done_at = cyc - s; end
    end
    checks++;
    if (n_done != 1 || done_at != LAT) begin
      errors++; $display("FAIL overlap_done: got count=%0d at=%0d want 1 at %0d", n_done, done_at, LAT);
    end
    checks++;
    if (phase_pos !== 1 || overlap_err !== 1 || dec_count !== 0) begin
      errors++; $display("FAIL overlap_result: got pos=%0d ovl=%b dec=%0d want 1 1 0", phase_pos, overlap_err, dec_count);
    end
    err_clr = 1; tick(); err_clr = 0;
    checks++;
    if (overlap_err !== 0) begin errors++; $display("FAIL overlap_clear: got %b want 0", overlap_err); end
    // clear and a fresh violation in the same cycle: the set must win
    psen = 1; tick(); psen = 1; err_clr = 1; tick(); psen = 0; err_clr = 0;
    checks++;
    if (overlap_err !== 1) begin errors++; $display("FAIL overlap_set_wins: got %b want 1", overlap_err); end
    repeat (LAT + 2) tick();
  endtask

  task automatic test_unlocked();
    int n_done = 0; int busy_seen = 0;
    do_reset();
    locked = 0; psen = 1; psincdec = 1; tick(); psen = 0;
    repeat (20) begin tick(); if (psdone) n_done++; if (busy) busy_seen++; end
    checks++;
    if (n_done != 0 || busy_seen != 0) begin
      errors++; $display("FAIL unlocked_ignored: got psdone=%0d busy=%0d want 0 0", n_done, busy_seen);
    end
    checks++;
    if (unlocked_err !== 1 || phase_pos !== 0 || inc_count !== 0) begin
      errors++; $display("FAIL unlocked_result: got unl=%b pos=%0d inc=%0d want 1 0 0", unlocked_err, phase_pos, inc_count);
    end
    locked = 1; err_clr = 1; tick(); err_clr = 0;
    checks++;
    if (unlocked_err !== 0) begin errors++; $display("FAIL unlocked_clear: got %b want 0", unlocked_err); end
  endtask

  task automatic test_lock_drop_and_dir();
    bit seen; int waited;
    do_reset();
    psen = 1; psincdec = 1; tick(); psen = 0;
    locked = 0; psincdec = 0;
    repeat (3) tick();
    psincdec = 1; tick(); psincdec = 0;
    wait_done(LAT + 8, seen, waited);
    checks++;
    if (!seen || waited != LAT - 5) begin
      errors++; $display("FAIL lockdrop_done: got seen=%b after=%0d want 1 after %0d", seen, waited, LAT - 5);
    end
    checks++;
    if (inc_count !== 1 || dec_count !== 0 || phase_pos !== 1 || unlocked_err !== 0) begin
      errors++; $display("FAIL lockdrop_result: got inc=%0d dec=%0d pos=%0d unl=%b want 1 0 1 0",
                         inc_count, dec_count, phase_pos, unlocked_err);
    end
    locked = 1; tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      psen     = ($urandom_range(0, 3) == 0);
      psincdec = $urandom_range(0, 1);
      locked   = ($urandom_range(0, 9) != 0);
      err_clr  = ($urandom_range(0, 24) == 0);
      tick();
      checks++;
      if (psdone !== m_psdone || busy !== m_busy) begin
        errors++; $display("FAIL rand_handshake cyc %0d: got done=%b busy=%b want %b %b", cyc, psdone, busy, m_psdone, m_busy);
      end
      checks++;
      if (phase_pos !== m_phase || phase_mod !== m_mod) begin
        errors++; $display("FAIL rand_phase cyc %0d: got pos=%0d mod=%0d want %0d %0d", cyc, phase_pos, phase_mod, m_phase, m_mod);
      end
      checks++;
      if (inc_count !== m_inc || dec_count !== m_dec) begin
        errors++; $display("FAIL rand_counts cyc %0d: got inc=%0d dec=%0d want %0d %0d", cyc, inc_count, dec_count, m_inc, m_dec);
      end
      checks++;
      if (overlap_err !== m_ovl || unlocked_err !== m_unl) begin
        errors++; $display("FAIL rand_errs cyc %0d: got ovl=%b unl=%b want %b %b", cyc, overlap_err, unlocked_err, m_ovl, m_unl);
      end
    end
    psen = 0; err_clr = 0; locked = 1;
    repeat (LAT + 2) tick();
  endtask

  task automatic test_reset_mid_shift();
    bit seen; int waited; int n_done = 0;
    // leave an error flag set so the reset has something to clear
    locked = 0; psen = 1; tick(); locked = 1;
    psincdec = 1; tick(); psen = 0;
    repeat (5) tick();
    reset_n = 0;
    #2;
    checks++;
    if ({psdone, busy, overlap_err, unlocked_err} !== 4'b0 || phase_pos !== 0 || phase_mod !== 0 ||
        inc_count !== 0 || dec_count !== 0) begin
      errors++; $display("FAIL midreset_async: got done=%b busy=%b ovl=%b unl=%b pos=%0d mod=%0d inc=%0d dec=%0d want all 0",
                         psdone, busy, overlap_err, unlocked_err, phase_pos, phase_mod, inc_count, dec_count);
    end
    @(posedge psclk); @(posedge psclk); #1; cyc += 2;
    model_clear();
    reset_n = 1;
    repeat (20) begin tick(); if (psdone || busy) n_done++; end
    checks++;
    if (n_done != 0 || phase_pos !== 0) begin
      errors++; $display("FAIL midreset_abandon: got activity=%0d pos=%0d want 0 0", n_done, phase_pos);
    end
    psen = 1; psincdec = 1; tick(); psen = 0;
    wait_done(LAT + 8, seen, waited);
    checks++;
    if (!seen || waited != LAT - 1 || phase_pos !== 1) begin
      errors++; $display("FAIL midreset_recover: got seen=%b after=%0d pos=%0d want 1 after %0d pos 1",
                         seen, waited, phase_pos, LAT - 1);
    end
  endtask

  initial begin
    test_reset();
    test_single_inc();
    test_back_to_back_wrap();
    test_dec_from_zero();
    test_overlap();
    test_unlocked();
    test_lock_drop_and_dir();
    test_random();
    test_reset_mid_shift();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
